gpio_irq_ctrl: RTL
==================

// Module: gpio_irq_ctrl
// PURPOSE
//  APB-programmable interrupt controller for the per-pin edge pulses from gpio_ip (irqsx_gpio_pedge/nedge).
//  Latches enabled edges into a pending register, picks the lowest-index pending pin and drives one
//  level IRQ to the CPU. Serviced with a claim/complete handshake. Sits beside gpio_ip on the APB bus.
// PARAMETERS
//  N_PINS  16  number of GPIO edge sources (1..16; ID field is 4 bits)
//  ADDR_W  32  APB address width
//  DATA_W  32  APB data width
// PORTS
//  PCLK        in   1       single clock
//  PRESETn     in   1       async assert, active-low reset
//  PADDR       in   ADDR_W  APB address; only [7:0] decoded
//  PWRITE      in   1       APB write
//  PWDATA      in   DATA_W  APB write data
//  PSTRB       in   4       byte strobes
//  PSEL        in   1       APB select
//  PENABLE     in   1       APB access phase
//  PRDATA      out  DATA_W  read data, valid in access phase
//  PREADY      out  1       tied 1 (zero wait)
//  PSLVERR     out  1       error response, access phase only
//  gpio_pedge  in   N_PINS  1-cycle rising-edge pulses
//  gpio_nedge  in   N_PINS  1-cycle falling-edge pulses
//  irq_o       out  1       level IRQ to CPU
// BEHAVIOUR
//  Reset: PEN=NEN=PEND=0, state IDLE, in-service ID=0, irq_o=0, PRDATA=0, PSLVERR=0.
//  Access = PSEL&PENABLE; side effects only on access. Map (RW unless noted):
//   0x00 PEDGE_EN [N-1:0]; 0x04 NEDGE_EN [N-1:0] (PSTRB[0]->[7:0], PSTRB[1]->[15:8]);
//   0x08 PENDING read / write-1-to-clear (PSTRB ignored); 0x0C CLAIM (RO);
//   0x10 COMPLETE (WO, PWDATA[3:0]=ID); 0x14 STATUS RO {29'b0,state[1:0],irq_o} — state occupies [2:1].
//  Unmapped offset, write to CLAIM/STATUS, read of COMPLETE -> PSLVERR=1, no state change, PRDATA=0.
//  Pending: PEND <= (PEND & ~clr) | (gpio_pedge&PEN) | (gpio_nedge&NEN); set wins over clear in same cycle.
//   Edge with enable=0 is dropped (never latched). Clearing enable does not clear PEND.
//  Winner: lowest index i with PEND[i]&(PEN[i]|NEN[i]); combinational from registered PEND.
//  FSM (2-bit): IDLE=0, REQ=1, SERVICE=2.
//   IDLE -> REQ when any eligible pending bit (next cycle). irq_o=1 only in REQ (registered from state).
//   REQ: CLAIM read returns {1'b1,27'b0,ID} and clears PEND[ID] (set-wins applies), latches ID -> SERVICE.
//   REQ -> IDLE if eligible set empties (W1C or enables dropped) without claim.
//   SERVICE: irq_o=0; CLAIM read returns 0xFFFF_FFFF, no side effect.
//    COMPLETE with matching ID -> REQ if eligible set nonempty after this cycle's update, else IDLE.
//    COMPLETE with mismatched ID -> PSLVERR=1, stays SERVICE.
//  IDLE: CLAIM read -> 0xFFFF_FFFF; COMPLETE -> PSLVERR=1.
//  Latency: edge pulse at cycle t -> PEND at t+1 -> state REQ at t+2 -> irq_o high at t+3 (irq_o is registered from state).
//  Reset mid-operation: all state returns to reset values asynchronously; edges in reset are lost.
//  No nesting: one in-service ID at a time.
// STRUCTURE
//  Package gpio_irq_pkg: register offsets, FSM state enum, NO_IRQ=32'hFFFF_FFFF, ID width (4).
//  Sub-module gpio_irq_prio_enc: N_PINS-bit lowest-index priority encoder -> {valid, id[3:0]}.
//  Top holds APB decode, PEN/NEN/PEND regs, FSM, PRDATA/PSLVERR mux.
// TESTING
//  1. PEN=0x0001, pedge[0] pulse -> PEND=0x0001 next cycle, irq_o=1 two cycles after PEND; CLAIM=0x8000_0000,
//     PEND=0, irq_o=0; COMPLETE 0 -> IDLE.
//  2. PEN=0xFFFF, pedge=0x8010 same cycle -> CLAIM=0x8000_0004; COMPLETE 4 -> REQ, CLAIM=0x8000_000F.
//  3. NEN=0x0004, pedge[2] only -> PEND stays 0, irq_o stays 0; then nedge[2] -> irq_o=1.
//  4. PEN=0x0002, in REQ: W1C PENDING 0x0002 same cycle as pedge[1] -> PEND[1] remains 1.
//  5. In SERVICE id 3: COMPLETE 5 -> PSLVERR=1, state SERVICE; CLAIM -> 0xFFFF_FFFF; read 0x18 -> PSLVERR=1.
//  6. PRESETn low while in SERVICE -> irq_o=0, PEND/PEN/NEN=0, STATUS=0 immediately (no clock edge needed).

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO edge interrupt controller: register map,
// FSM encoding and CLAIM read formats.
package gpio_irq_pkg;

   localparam int ID_W = 4;

   localparam logic [7:0] OFF_PEDGE_EN = 8'h00;
   localparam logic [7:0] OFF_NEDGE_EN = 8'h04;
   localparam logic [7:0] OFF_PENDING  = 8'h08;
   localparam logic [7:0] OFF_CLAIM    = 8'h0C;
   localparam logic [7:0] OFF_COMPLETE = 8'h10;
   localparam logic [7:0] OFF_STATUS   = 8'h14;

   localparam logic [31:0] NO_IRQ = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

   // Successful CLAIM: valid flag in bit 31, winning pin ID in the low nibble.
   function automatic logic [31:0] claim_word(input logic [ID_W-1:0] id);
      return {1'b1, 27'b0, id};
   endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// APB3/4 bus bundle used by the GPIO interrupt controller.
interface gpio_irq_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic [3:0]        PSTRB;
   logic              PSEL;
   logic              PENABLE;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/gpio_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible pending pins.
module gpio_irq_prio_enc
   import gpio_irq_pkg::*;
#(
   parameter int N_PINS = 16
) (
   input  logic [N_PINS-1:0] req,
   output logic              valid,
   output logic [ID_W-1:0]   id
);

   always_comb begin
      valid = |req;
      id    = '0;
      // Scan downward so the lowest set index is the last one written.
      for (int unsigned i = N_PINS; i > 0; i--) begin
         if (req[i-1]) id = ID_W'(i - 1);
      end
   end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// APB-programmable interrupt controller for GPIO edge pulses: pending latch,
// lowest-index arbitration and a claim/complete serviced level IRQ.
module gpio_irq_ctrl
   import gpio_irq_pkg::*;
#(
   parameter int N_PINS = 16,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   gpio_irq_ctrl_if.slave     apb,
   input  logic [N_PINS-1:0]  gpio_pedge,
   input  logic [N_PINS-1:0]  gpio_nedge,
   output logic               irq_o
);

   irq_state_e        state;
   logic [ID_W-1:0]   svc_id;
   logic [N_PINS-1:0] pen, nen, pend;
   logic [N_PINS-1:0] pen_next, nen_next, pend_next, clr, w1c;
   logic [N_PINS-1:0] elig, elig_next;
   logic              win_valid;
   logic [ID_W-1:0]   win_id;

   logic [ADDR_W-1:0] paddr;
   logic [7:0]        off;
   logic              access;
   logic [DATA_W-1:0] rdata;
   logic              err, claim_take, cpl_ok, pen_we, nen_we;

   assign paddr  = apb.PADDR;
   assign off    = paddr[7:0];
   assign access = apb.PSEL & apb.PENABLE;

   assign elig = pend & (pen | nen);

   gpio_irq_prio_enc #(.N_PINS(N_PINS)) u_prio (
      .req   (elig),
      .valid (win_valid),
      .id    (win_id)
   );

   always_comb begin
      rdata      = '0;
      err        = 1'b0;
      claim_take = 1'b0;
      cpl_ok     = 1'b0;
      w1c        = '0;
      pen_we     = 1'b0;
      nen_we     = 1'b0;
      if (access) begin
         case (off)
            OFF_PEDGE_EN: if (apb.PWRITE) pen_we = 1'b1; else rdata = DATA_W'(pen);
            OFF_NEDGE_EN: if (apb.PWRITE) nen_we = 1'b1; else rdata = DATA_W'(nen);
            OFF_PENDING:  if (apb.PWRITE) w1c = apb.PWDATA[N_PINS-1:0]; else rdata = DATA_W'(pend);
            OFF_CLAIM: begin
               if (apb.PWRITE) err = 1'b1;
               else if (state == ST_REQ && win_valid) begin
                  rdata      = DATA_W'(claim_word(win_id));
                  claim_take = 1'b1;
               end else rdata = DATA_W'(NO_IRQ);
            end
            OFF_COMPLETE: begin
               if (apb.PWRITE && state == ST_SERVICE && apb.PWDATA[ID_W-1:0] == svc_id)
                  cpl_ok = 1'b1;
               else
                  err = 1'b1;
            end
            OFF_STATUS: if (apb.PWRITE) err = 1'b1; else rdata = DATA_W'({2'(state), irq_o});
            default:    err = 1'b1;
         endcase
      end
   end

   assign apb.PRDATA  = rdata;
   assign apb.PSLVERR = err;
   assign apb.PREADY  = 1'b1;

   always_comb begin
      pen_next = pen;
      nen_next = nen;
      for (int unsigned i = 0; i < N_PINS; i++) begin
         if (pen_we && apb.PSTRB[i/8]) pen_next[i] = apb.PWDATA[i];
         if (nen_we && apb.PSTRB[i/8]) nen_next[i] = apb.PWDATA[i];
      end
      clr = w1c;
      if (claim_take) clr[win_id] = 1'b1;
      // New edges are ORed in after the clear so a same-cycle set survives.
      pend_next = (pend & ~clr) | (gpio_pedge & pen) | (gpio_nedge & nen);
   end

   assign elig_next = pend_next & (pen_next | nen_next);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         pen  <= '0;
         nen  <= '0;
         pend <= '0;
      end else begin
         pen  <= pen_next;
         nen  <= nen_next;
         pend <= pend_next;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state  <= ST_IDLE;
         svc_id <= '0;
         irq_o  <= 1'b0;
      end else begin
         irq_o <= (state == ST_REQ);
         case (state)
            ST_IDLE: if (|elig) state <= ST_REQ;
            ST_REQ: begin
               if (claim_take) begin
                  svc_id <= win_id;
                  state  <= ST_SERVICE;
               end else if (!(|elig)) state <= ST_IDLE;
            end
            ST_SERVICE: if (cpl_ok) state <= (|elig_next) ? ST_REQ : ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
